// File: rtl/memory_address_pkg.sv
// Shared types and default widths for the memory address unit.
package memory_address_pkg;

  localparam int unsigned MAR_ADDR_WIDTH = 4;
  localparam int unsigned MAR_LEN_WIDTH  = MAR_ADDR_WIDTH;

  typedef enum logic [1:0] {
    MAR_IDLE  = 2'd0,
    MAR_BURST = 2'd1,
    MAR_FAULT = 2'd2
  } mar_state_t;

endpackage

// File: rtl/mar_burst_counter.sv
// Remaining-beat down-counter for bursts; last_c flags one beat left.
module mar_burst_counter #(
  parameter int unsigned LEN_WIDTH = memory_address_pkg::MAR_LEN_WIDTH
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_load,
  input  logic [LEN_WIDTH-1:0] i_load_value,
  input  logic                 i_decrement,
  output logic                 last_c
);

  logic [LEN_WIDTH-1:0] count;

  // Load takes priority over decrement; reset empties the counter.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_load_value;
    end else if (i_decrement) begin
      count <= count - LEN_WIDTH'(1);
    end
  end

  assign last_c = (count == LEN_WIDTH'(1));

endmodule

// File: rtl/memory_address_unit.sv
// Memory address register with single-step increment and valid/ready bursts.
// Optional limit checking is enabled by defining MAR_LIMIT_CHECK_EN.
module memory_address_unit
  import memory_address_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MAR_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_enable_in,
  input  logic                  i_increment,
  input  logic                  i_burst_start,
  input  logic [LEN_WIDTH-1:0]  i_burst_len,
  input  logic                  i_ready,
  input  logic [ADDR_WIDTH-1:0] i_limit,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fault
);

  mar_state_t state;
  logic       start_c;
  logic       beat_c;
  logic       last_c;
  logic       start_over_limit_c;
  logic       at_limit_c;

  // Burst request that is not cancelled by a zero length.
  assign start_c = i_burst_start && (i_burst_len != '0);
  assign beat_c  = (state == MAR_BURST) && o_valid && i_ready;

`ifdef MAR_LIMIT_CHECK_EN
  // Limit comparisons against the current and requested start address.
  assign at_limit_c         = (o_address == i_limit);
  assign start_over_limit_c = (i_address > i_limit);
`else
  logic unused_limit;
  assign unused_limit       = ^i_limit;
  assign at_limit_c         = 1'b0;
  assign start_over_limit_c = 1'b0;
`endif

  mar_burst_counter #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_burst_counter (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_load      ((state == MAR_IDLE) && start_c),
    .i_load_value(i_burst_len),
    .i_decrement (beat_c),
    .last_c      (last_c)
  );

  // Address register and control FSM with registered status outputs.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state     <= MAR_IDLE;
      o_address <= ADDR_WIDTH'(RESET_ADDR);
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_fault   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        MAR_IDLE: begin
          if (start_c) begin
            if (start_over_limit_c) begin
              state   <= MAR_FAULT;
              o_busy  <= 1'b1;
              o_fault <= 1'b1;
            end else begin
              state     <= MAR_BURST;
              o_address <= i_address;
              o_valid   <= 1'b1;
              o_busy    <= 1'b1;
            end
          end else if (i_enable_in) begin
            o_address <= i_address;
          end else if (i_increment) begin
            if (at_limit_c) begin
              state   <= MAR_FAULT;
              o_busy  <= 1'b1;
              o_fault <= 1'b1;
            end else begin
              o_address <= o_address + ADDR_WIDTH'(1);
            end
          end
        end
        MAR_BURST: begin
          if (beat_c) begin
            if (at_limit_c && !last_c) begin
              state   <= MAR_FAULT;
              o_valid <= 1'b0;
              o_fault <= 1'b1;
            end else begin
              o_address <= o_address + ADDR_WIDTH'(1);
              if (last_c) begin
                state   <= MAR_IDLE;
                o_valid <= 1'b0;
                o_busy  <= 1'b0;
                o_done  <= 1'b1;
              end
            end
          end
        end
        MAR_FAULT: begin
          if (i_enable_in) begin
            state     <= MAR_IDLE;
            o_address <= i_address;
            o_busy    <= 1'b0;
            o_fault   <= 1'b0;
          end
        end
        default: begin
          state   <= MAR_IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_fault <= 1'b0;
        end
      endcase
    end
  end

endmodule
